// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: the requester drives start and the
// operands, the divider returns status and registered results.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, STEPS_PER_CYCLE quotient bits per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a FIX cycle).
module seq_divider #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic         clock,
    input  logic         clear,
    seq_divider_if.slave bus
);
    localparam int NCYC = WIDTH / STEPS_PER_CYCLE;
    localparam int CW   = $clog2(NCYC + 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] mreg;
    logic [WIDTH-1:0] dvd;
    logic [CW-1:0]    cnt;
    logic             busy_r, done_r, dbz_r;
    logic [WIDTH-1:0] quo_r, rem_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             neg_q, neg_r;
`endif

    // Chained restoring steps; the partial remainder stays below M so the
    // shifted value always fits in WIDTH+1 bits.
    logic [WIDTH:0]   a_t, diff;
    logic [WIDTH-1:0] q_t;
    always_comb begin
        a_t  = {1'b0, acc};
        q_t  = qreg;
        diff = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            a_t  = {a_t[WIDTH-1:0], q_t[WIDTH-1]};
            q_t  = {q_t[WIDTH-2:0], 1'b0};
            diff = a_t - {1'b0, mreg};
            if (!diff[WIDTH]) begin
                a_t    = diff;
                q_t[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
            acc    <= '0;
            qreg   <= '0;
            mreg   <= '0;
            dvd    <= '0;
            cnt    <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        cnt    <= CW'(NCYC);
                        dvd    <= bus.dividend;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        qreg   <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                        mreg   <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                        neg_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r  <= bus.dividend[WIDTH-1];
`else
                        qreg   <= bus.dividend;
                        mreg   <= bus.divisor;
`endif
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (mreg == '0) begin
                        quo_r  <= '1;
                        rem_r  <= dvd;
                        dbz_r  <= 1'b1;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= DONE;
                    end else begin
                        acc  <= a_t[WIDTH-1:0];
                        qreg <= q_t;
                        cnt  <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                            state  <= FIX;
`else
                            quo_r  <= q_t;
                            rem_r  <= a_t[WIDTH-1:0];
                            dbz_r  <= 1'b0;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= DONE;
`endif
                        end
                    end
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                // Magnitudes are done; restore truncate-toward-zero signs.
                FIX: begin
                    quo_r  <= neg_q ? -qreg : qreg;
                    rem_r  <= neg_r ? -acc  : acc;
                    dbz_r  <= 1'b0;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= DONE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: random and directed operations on a
// 1-step and a 4-step instance, checked against plain-arithmetic division.
module tb_seq_divider;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int SGN = 1;
`else
    localparam int SGN = 0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb1[$];
    exp_t sb4[$];
    logic [31:0] last_q1 = '0, last_r1 = '0;
    logic        last_z1 = 1'b0;

    seq_divider_if #(.WIDTH(32)) b1();
    seq_divider_if #(.WIDTH(32)) b4();

    seq_divider #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut1 (.clock(clock), .clear(clear), .bus(b1));
    seq_divider #(.WIDTH(32), .STEPS_PER_CYCLE(4)) dut4 (.clock(clock), .clear(clear), .bus(b4));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sn, sd;
        if (d == 0) begin
            q = '1; r = n; z = 1'b1;
        end else begin
            if (SGN == 1) begin
                sn = longint'(signed'(n));
                sd = longint'(signed'(d));
            end else begin
                sn = longint'({32'd0, n});
                sd = longint'({32'd0, d});
            end
            q = 32'(sn / sd);
            r = 32'(sn % sd);
            z = 1'b0;
        end
    endfunction

    // Monitors: pop one expectation per done pulse and check value and timing.
    always @(negedge clock) begin
        exp_t e;
        if (b1.done === 1'b1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done1: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb1.pop_front();
                chk("quotient1", b1.quotient, e.q);
                chk("remainder1", b1.remainder, e.r);
                chk("dbz1", b1.div_by_zero, e.z);
                chk("done_cycle1", cyc, e.due);
                chk("busy_in_done1", b1.busy, 1'b0);
                last_q1 = e.q; last_r1 = e.r; last_z1 = e.z;
            end
        end
        if (b4.done === 1'b1) begin
            if (sb4.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done4: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb4.pop_front();
                chk("quotient4", b4.quotient, e.q);
                chk("remainder4", b4.remainder, e.r);
                chk("dbz4", b4.div_by_zero, e.z);
                chk("done_cycle4", cyc, e.due);
            end
        end
    end

    // Called at a negedge; waits for the unit to accept, then scrambles inputs.
    task automatic issue(input int which, input logic [31:0] n, input logic [31:0] d);
        exp_t e;
        int   budget;
        budget = 0;
        while (((which == 1) ? b1.busy : b4.busy) !== 1'b0 && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 200) begin
            checks++; errors++;
            $display("FAIL busy_timeout%0d: got busy stuck expected idle", which);
        end
        model(n, d, e.q, e.r, e.z);
        e.due = cyc + 1 + ((d == 0) ? 1 : (((which == 1) ? 32 : 8) + SGN));
        if (which == 1) begin
            b1.start = 1'b1; b1.dividend = n; b1.divisor = d; sb1.push_back(e);
        end else begin
            b4.start = 1'b1; b4.dividend = n; b4.divisor = d; sb4.push_back(e);
        end
        @(negedge clock);
        if (which == 1) begin
            b1.start = 1'b0; b1.dividend = $urandom; b1.divisor = $urandom;
            if (d != 0) chk("busy_after_start1", b1.busy, 1'b1);
        end else begin
            b4.start = 1'b0; b4.dividend = $urandom; b4.divisor = $urandom;
            if (d != 0) chk("busy_after_start4", b4.busy, 1'b1);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sb1.size() != 0 || sb4.size() != 0) && budget < 400) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 400) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", sb1.size(), sb4.size());
        end
    endtask

    function automatic logic [31:0] rand_divisor();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 32'd0;
        if (k < 5) return 32'($urandom_range(1, 255));
        return $urandom;
    endfunction

    initial begin
        logic [31:0] dv [6];
        logic [31:0] ds [6];
        dv = '{32'd100, 32'h12345678, 32'hFFFFFFFF, 32'd5, 32'hFFFFFF9C, 32'h80000000};
        ds = '{32'd7,   32'd0,        32'd1,        32'd9, 32'd7,        32'hFFFFFFFF};
        b1.start = 1'b0; b1.dividend = '0; b1.divisor = '0;
        b4.start = 1'b0; b4.dividend = '0; b4.divisor = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", b1.busy, 1'b0);
        chk("rst_done", b1.done, 1'b0);
        chk("rst_quotient", b1.quotient, 32'd0);
        chk("rst_remainder", b1.remainder, 32'd0);
        chk("rst_dbz", b1.div_by_zero, 1'b0);
        clear = 1'b0;

        // 100/7 with a start pulse mid-run that must be ignored.
        issue(1, dv[0], ds[0]);
        repeat (8) @(negedge clock);
        b1.start = 1'b1; b1.dividend = 32'd999; b1.divisor = 32'd3;
        @(negedge clock);
        b1.start = 1'b0;
        drain();
        repeat (3) @(negedge clock);
        chk("hold_quotient", b1.quotient, last_q1);
        chk("hold_remainder", b1.remainder, last_r1);
        chk("hold_dbz", b1.div_by_zero, last_z1);

        // Remaining directed vectors, back-to-back.
        for (int i = 1; i < 6; i++) issue(1, dv[i], ds[i]);
        drain();

        // Random back-to-back stream.
        for (int i = 0; i < 30; i++) issue(1, $urandom, rand_divisor());
        drain();

        // Abort mid-run; outputs must zero and the aborted op never completes.
        issue(1, $urandom, 32'd13);
        repeat (5) @(negedge clock);
        clear = 1'b1;
        sb1.delete();
        @(negedge clock);
        clear = 1'b0;
        chk("clr_busy", b1.busy, 1'b0);
        chk("clr_done", b1.done, 1'b0);
        chk("clr_quotient", b1.quotient, 32'd0);
        chk("clr_remainder", b1.remainder, 32'd0);
        chk("clr_dbz", b1.div_by_zero, 1'b0);
        last_q1 = '0; last_r1 = '0; last_z1 = 1'b0;
        issue(1, 32'd1000, 32'd3);
        drain();

        // Four steps per clock.
        issue(4, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) issue(4, $urandom, rand_divisor());
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule
